// File: rtl/isi_ms_sel_decoder.sv
// Receive-side decoder/checker for the ISI/MS B (18-elem) and C (6-elem) selection outputs.
// Latency: SV/ST sampled on qualified edge N, VB_dec/VC_dec/dec_vld/flags registered on qualified edge N+1.
// No backpressure: every clk_en sample is consumed; clk_en=0 freezes all state and holds outputs.
//
// Ports: clk, rst (async, active-high), clk_en (sample qualifier), chk_en (compare/count enable),
//   clr (sync clear, beats clk_en), VB_ref/VC_ref (encoder input codes), SVB/STB, SVC/STC (selection
//   and transition vectors), VB_dec/VC_dec/dec_vld (decoded codes), mis_b/mis_c/st_err (per-sample
//   error pulses), err_sticky, err_cnt, tcnt_b/tcnt_c (saturating statistics).
module isi_ms_sel_decoder #(
   parameter int REF_DLY = 2,
   parameter int ECNT_W  = 16,
   parameter int TCNT_W  = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   input  logic                chk_en,
   input  logic                clr,
   input  logic signed [5:0]   VB_ref,
   input  logic signed [3:0]   VC_ref,
   input  logic [17:0]         SVB,
   input  logic [17:0]         STB,
   input  logic [5:0]          SVC,
   input  logic [5:0]          STC,
   output logic signed [5:0]   VB_dec,
   output logic signed [3:0]   VC_dec,
   output logic                dec_vld,
   output logic                mis_b,
   output logic                mis_c,
   output logic                st_err,
   output logic                err_sticky,
   output logic [ECNT_W-1:0]   err_cnt,
   output logic [TCNT_W-1:0]   tcnt_b,
   output logic [TCNT_W-1:0]   tcnt_c
);

   // Warm-up counter saturates at REF_DLY+1: that many samples must have been
   // captured before the reference tap holds the code matching the stage-1 SV.
   localparam int             WW   = $clog2(REF_DLY + 2);
   localparam logic [WW-1:0]  WARM = WW'(REF_DLY + 1);

   typedef struct packed {
      logic [17:0]              svb;
      logic [17:0]              stb;
      logic [17:0]              prev_b;
      logic [5:0]               svc;
      logic [5:0]               stc;
      logic [5:0]               prev_c;
      logic [REF_DLY-1:0][5:0]  dly_b;
      logic [REF_DLY-1:0][3:0]  dly_c;
      logic [5:0]               ref_b;
      logic [3:0]               ref_c;
      logic                     s1_vld;
      logic                     prev_vld;
      logic [WW-1:0]            wcnt;
      logic [5:0]               vb_dec;
      logic [3:0]               vc_dec;
      logic                     dec_vld;
      logic                     mis_b;
      logic                     mis_c;
      logic                     st_err;
      logic                     err_sticky;
      logic [ECNT_W-1:0]        err_cnt;
      logic [TCNT_W-1:0]        tcnt_b;
      logic [TCNT_W-1:0]        tcnt_c;
   } state_t;

   state_t q, d;

   logic [17:0]       xb;
   logic [5:0]        xc;
   logic [4:0]        pc_b, pc_bt;
   logic [2:0]        pc_c, pc_ct;
   logic [5:0]        dec_b;
   logic [3:0]        dec_c;
   logic              chk, mis_b_n, mis_c_n, st_n, any_err, tick;
   logic [TCNT_W:0]   tsum_b, tsum_c;

   // Element toggles since the previous sample; doubles as the expected ST vector.
   assign xb = q.svb ^ q.prev_b;
   assign xc = q.svc ^ q.prev_c;

   always_comb begin
      pc_b  = '0;
      pc_bt = '0;
      pc_c  = '0;
      pc_ct = '0;
      for (int i = 0; i < 18; i++) begin
         pc_b  = pc_b  + {4'd0, q.svb[i]};
         pc_bt = pc_bt + {4'd0, xb[i]};
      end
      for (int i = 0; i < 6; i++) begin
         pc_c  = pc_c  + {2'd0, q.svc[i]};
         pc_ct = pc_ct + {2'd0, xc[i]};
      end
   end

   assign dec_b   = {1'b0, pc_b} - 6'd9;
   assign dec_c   = {1'b0, pc_c} - 4'd3;
   assign chk     = (q.wcnt == WARM) & chk_en;
   assign mis_b_n = chk & (dec_b != q.ref_b);
   assign mis_c_n = chk & (dec_c != q.ref_c);
   // ST history is meaningless until one sample has been seen since rst/clr.
   assign st_n    = chk & q.prev_vld & ((q.stb != xb) | (q.stc != xc));
   assign any_err = mis_b_n | mis_c_n | st_n;
   assign tick    = chk & q.prev_vld;
   assign tsum_b  = {1'b0, q.tcnt_b} + {{(TCNT_W-4){1'b0}}, pc_bt};
   assign tsum_c  = {1'b0, q.tcnt_c} + {{(TCNT_W-2){1'b0}}, pc_ct};

   always_comb begin
      d         = q;
      d.dec_vld = 1'b0;
      d.mis_b   = 1'b0;
      d.mis_c   = 1'b0;
      d.st_err  = 1'b0;
      if (clr) begin
         d = '0;
      end else if (clk_en) begin
         // Stage 1: capture vectors; the oldest tap leaves the line alongside
         // its SV so both reach stage 2 together.
         d.svb    = SVB;
         d.stb    = STB;
         d.svc    = SVC;
         d.stc    = STC;
         d.ref_b  = q.dly_b[REF_DLY-1];
         d.ref_c  = q.dly_c[REF_DLY-1];
         for (int i = REF_DLY - 1; i >= 1; i--) begin
            d.dly_b[i] = q.dly_b[i-1];
            d.dly_c[i] = q.dly_c[i-1];
         end
         d.dly_b[0] = VB_ref;
         d.dly_c[0] = VC_ref;
         d.s1_vld   = 1'b1;
         if (q.wcnt != WARM) d.wcnt = q.wcnt + 1'b1;

         // Stage 2: decode and check the sample captured on the previous qualified edge.
         if (q.s1_vld) begin
            d.vb_dec  = dec_b;
            d.vc_dec  = dec_c;
            d.dec_vld = 1'b1;
            d.mis_b   = mis_b_n;
            d.mis_c   = mis_c_n;
            d.st_err  = st_n;
            if (any_err) begin
               d.err_sticky = 1'b1;
               if (q.err_cnt != '1) d.err_cnt = q.err_cnt + 1'b1;
            end
            if (tick) begin
               d.tcnt_b = tsum_b[TCNT_W] ? '1 : tsum_b[TCNT_W-1:0];
               d.tcnt_c = tsum_c[TCNT_W] ? '1 : tsum_c[TCNT_W-1:0];
            end
            // History tracks even when checking is disabled.
            d.prev_b   = q.svb;
            d.prev_c   = q.svc;
            d.prev_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else     q <= d;
   end

   assign VB_dec     = q.vb_dec;
   assign VC_dec     = q.vc_dec;
   assign dec_vld    = q.dec_vld;
   assign mis_b      = q.mis_b;
   assign mis_c      = q.mis_c;
   assign st_err     = q.st_err;
   assign err_sticky = q.err_sticky;
   assign err_cnt    = q.err_cnt;
   assign tcnt_b     = q.tcnt_b;
   assign tcnt_c     = q.tcnt_c;

endmodule

// File: tb/tb_isi_ms_sel_decoder.sv
// Bench for isi_ms_sel_decoder: an encoder model drives SV/ST from delayed codes,
// a reference model queues expected outputs, a negedge monitor pops and compares.
// Narrow ECNT_W makes error-counter saturation reachable in a short run.
module tb_isi_ms_sel_decoder;
   localparam int REF_DLY = 2;
   localparam int ECNT_W  = 4;
   localparam int TCNT_W  = 20;
   localparam int EMAX    = (1 << ECNT_W) - 1;
   localparam longint TMAX = (64'd1 << TCNT_W) - 1;

   logic clk = 1'b0;
   logic rst, clk_en, chk_en, clr;
   logic [5:0]  VB_ref;
   logic [3:0]  VC_ref;
   logic [17:0] SVB, STB;
   logic [5:0]  SVC, STC;
   logic [5:0]  VB_dec;
   logic [3:0]  VC_dec;
   logic dec_vld, mis_b, mis_c, st_err, err_sticky;
   logic [ECNT_W-1:0] err_cnt;
   logic [TCNT_W-1:0] tcnt_b, tcnt_c;

   always #5 clk = ~clk;

   isi_ms_sel_decoder #(.REF_DLY(REF_DLY), .ECNT_W(ECNT_W), .TCNT_W(TCNT_W)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .chk_en(chk_en), .clr(clr),
      .VB_ref(VB_ref), .VC_ref(VC_ref), .SVB(SVB), .STB(STB), .SVC(SVC), .STC(STC),
      .VB_dec(VB_dec), .VC_dec(VC_dec), .dec_vld(dec_vld), .mis_b(mis_b), .mis_c(mis_c),
      .st_err(st_err), .err_sticky(err_sticky), .err_cnt(err_cnt), .tcnt_b(tcnt_b), .tcnt_c(tcnt_c));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [5:0]        vb;
      logic [3:0]        vc;
      logic              mb, mc, st, sticky;
      logic [ECNT_W-1:0] ec;
      logic [TCNT_W-1:0] tb, tc;
   } exp_t;

   exp_t q_exp[$];

   // Reference model state
   int          mk;
   logic [5:0]  mref_b[$];
   logic [3:0]  mref_c[$];
   bit          p_vld;
   int          p_k;
   logic [17:0] p_svb, p_stb, m_prev_b;
   logic [5:0]  p_svc, p_stc, m_prev_c;
   logic        m_sticky;
   int          m_ec;
   longint      m_tb, m_tc;
   logic [5:0]  last_vb;
   logic [3:0]  last_vc;
   logic [ECNT_W-1:0] last_ec;

   // Encoder model state
   int          bk;
   logic [5:0]  hist_b[$];
   logic [3:0]  hist_c[$];
   logic [17:0] ep_b;
   logic [5:0]  ep_c;

   task automatic model_reset();
      q_exp.delete(); mref_b.delete(); mref_c.delete();
      mk = 0; p_vld = 0; p_k = 0;
      m_prev_b = '0; m_prev_c = '0; m_sticky = 0; m_ec = 0; m_tb = 0; m_tc = 0;
      last_vb = '0; last_vc = '0; last_ec = '0;
      bk = 0; hist_b.delete(); hist_c.delete();
   endtask

   task automatic eval_pending(input logic ck);
      exp_t e;
      bit warm, chk;
      logic [5:0] rb;
      logic [3:0] rc;
      warm = (p_k >= REF_DLY);
      chk  = warm && ck;
      rb   = warm ? mref_b[p_k-REF_DLY] : 6'd0;
      rc   = warm ? mref_c[p_k-REF_DLY] : 4'd0;
      e.vb = 6'($countones(p_svb)) - 6'd9;
      e.vc = 4'($countones(p_svc)) - 4'd3;
      e.mb = chk && (e.vb != rb);
      e.mc = chk && (e.vc != rc);
      e.st = chk && (p_k >= 1) && ((p_stb != (p_svb ^ m_prev_b)) || (p_stc != (p_svc ^ m_prev_c)));
      if (chk && p_k >= 1) begin
         m_tb = m_tb + $countones(p_svb ^ m_prev_b);
         m_tc = m_tc + $countones(p_svc ^ m_prev_c);
         if (m_tb > TMAX) m_tb = TMAX;
         if (m_tc > TMAX) m_tc = TMAX;
      end
      if (e.mb || e.mc || e.st) begin
         m_sticky = 1'b1;
         if (m_ec < EMAX) m_ec++;
      end
      e.sticky = m_sticky;
      e.ec     = ECNT_W'(m_ec);
      e.tb     = TCNT_W'(m_tb);
      e.tc     = TCNT_W'(m_tc);
      m_prev_b = p_svb;
      m_prev_c = p_svc;
      q_exp.push_back(e);
   endtask

   task automatic drive(input logic ce, input logic ck, input logic cl,
                        input logic [5:0] rb, input logic [3:0] rc,
                        input logic [17:0] svb, input logic [17:0] stb,
                        input logic [5:0] svc, input logic [5:0] stc);
      @(negedge clk); #1;
      clk_en = ce; chk_en = ck; clr = cl;
      VB_ref = rb; VC_ref = rc; SVB = svb; STB = stb; SVC = svc; STC = stc;
      if (cl) begin
         model_reset();
      end else if (ce) begin
         if (p_vld) eval_pending(ck);
         p_svb = svb; p_stb = stb; p_svc = svc; p_stc = stc; p_k = mk;
         mref_b.push_back(rb); mref_c.push_back(rc);
         mk++; p_vld = 1;
      end
   endtask

   // Encoder: SV of sample k encodes the code presented lag+REF_DLY samples earlier.
   task automatic enc(input logic ce, input logic ck, input logic [5:0] rb, input logic [3:0] rc,
                      input int flip, input int lag, input bit rnd_pos);
      logic [5:0]  code_b;
      logic [3:0]  code_c;
      logic [17:0] svb, stb;
      logic [5:0]  svc, stc;
      logic [31:0] m32;
      int nb, nc, idx, rot;
      if (!ce) begin
         drive(1'b0, ck, 1'b0, 6'($urandom), 4'($urandom), 18'($urandom), 18'($urandom),
               6'($urandom), 6'($urandom));
         return;
      end
      idx    = bk - REF_DLY - lag;
      code_b = (idx >= 0) ? hist_b[idx] : 6'd0;
      code_c = (idx >= 0) ? hist_c[idx] : 4'd0;
      nb = int'($signed(code_b)) + 9;
      nc = int'($signed(code_c)) + 3;
      if (nb < 0) nb = 0;
      if (nb > 18) nb = 18;
      if (nc < 0) nc = 0;
      if (nc > 6) nc = 6;
      m32 = (32'd1 << nb) - 32'd1;
      svb = m32[17:0];
      m32 = (32'd1 << nc) - 32'd1;
      svc = m32[5:0];
      if (rnd_pos) begin
         rot = $urandom_range(0, 17);
         svb = (svb << rot) | (svb >> (18 - rot));
         rot = $urandom_range(0, 5);
         svc = (svc << rot) | (svc >> (6 - rot));
      end
      stb = svb ^ ep_b;
      stc = svc ^ ep_c;
      if (flip >= 0) stb[flip] = ~stb[flip];
      ep_b = svb; ep_c = svc;
      hist_b.push_back(rb); hist_c.push_back(rc); bk++;
      drive(1'b1, ck, 1'b0, rb, rc, svb, stb, svc, stc);
   endtask

   task automatic rand_enc(input logic ck, input int flip, input int lag);
      int vb, vc;
      vb = $urandom_range(0, 18) - 9;
      vc = $urandom_range(0, 6) - 3;
      enc(1'b1, ck, 6'(vb), 4'(vc), flip, lag, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_vb"}, 32'(VB_dec), 32'd0);
      check({tag, "_vc"}, 32'(VC_dec), 32'd0);
      check({tag, "_flags"}, 32'({dec_vld, mis_b, mis_c, st_err, err_sticky}), 32'd0);
      check({tag, "_ecnt"}, 32'(err_cnt), 32'd0);
      check({tag, "_tcnt"}, 32'(tcnt_b) | 32'(tcnt_c), 32'd0);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (dec_vld) begin
            if (q_exp.size() == 0) begin
               check("unexpected_vld", 32'(dec_vld), 32'd0);
            end else begin
               mon_e = q_exp.pop_front();
               check("vb_dec", 32'(VB_dec), 32'(mon_e.vb));
               check("vc_dec", 32'(VC_dec), 32'(mon_e.vc));
               check("mis_b", 32'(mis_b), 32'(mon_e.mb));
               check("mis_c", 32'(mis_c), 32'(mon_e.mc));
               check("st_err", 32'(st_err), 32'(mon_e.st));
               check("sticky", 32'(err_sticky), 32'(mon_e.sticky));
               check("err_cnt", 32'(err_cnt), 32'(mon_e.ec));
               check("tcnt_b", 32'(tcnt_b), 32'(mon_e.tb));
               check("tcnt_c", 32'(tcnt_c), 32'(mon_e.tc));
               last_vb = mon_e.vb; last_vc = mon_e.vc; last_ec = mon_e.ec;
            end
         end else begin
            check("hold_vb", 32'(VB_dec), 32'(last_vb));
            check("hold_vc", 32'(VC_dec), 32'(last_vc));
            check("idle_pulse", 32'({mis_b, mis_c, st_err}), 32'd0);
            check("hold_ecnt", 32'(err_cnt), 32'(last_ec));
         end
      end
   end

   initial begin
      ep_b = '0; ep_c = '0;
      model_reset();
      rst = 1'b1; clk_en = 0; chk_en = 1; clr = 0;
      VB_ref = '0; VC_ref = '0; SVB = '0; STB = '0; SVC = '0; STC = '0;
      #1;
      check_zero("reset");
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      // Mid-scale codes held: decode 0, no toggles, no errors.
      repeat (8) enc(1'b1, 1'b1, 6'd0, 4'd0, -1, 0, 1'b0);

      // Full-scale alternation: every element toggles each sample.
      for (int i = 0; i < 8; i++)
         enc(1'b1, 1'b1, (i % 2) ? 6'h37 : 6'd9, (i % 2) ? 4'hD : 4'd3, -1, 0, 1'b0);

      // Random matching codes with one corrupted ST bit.
      for (int i = 0; i < 8; i++) rand_enc(1'b1, (i == 3) ? 4 : -1, 0);

      // Out-of-range reference: encoder can only clamp, decoder must flag it.
      enc(1'b1, 1'b1, 6'd12, 4'd0, -1, 0, 1'b0);
      repeat (4) rand_enc(1'b1, -1, 0);
      for (int i = 0; i < 3; i++) rand_enc(1'b1, 7 + i, 0);
      repeat (2) rand_enc(1'b1, -1, 0);
      check("ecnt_pre_rst", 32'(err_cnt), 32'(m_ec));
      check("ecnt_is_5", 32'(err_cnt), 32'd5);

      // Asynchronous reset mid-stream, no clock edge needed.
      @(negedge clk); #2;
      clk_en = 0; clr = 0; rst = 1'b1;
      #1;
      check_zero("midrst");
      model_reset();
      @(negedge clk); #2 rst = 1'b0;

      repeat (6) rand_enc(1'b1, 11, 0);
      // clr with clk_en=1: sample discarded, warm-up restarts; first ST after is not checked.
      drive(1'b1, 1'b1, 1'b1, 6'd5, 4'd1, 18'h3FFFF, 18'h0, 6'h3F, 6'h0);
      @(negedge clk); #1;
      check("clr_sticky", 32'(err_sticky), 32'd0);
      check("clr_ecnt", 32'(err_cnt), 32'd0);
      rand_enc(1'b1, 2, 0);
      repeat (5) rand_enc(1'b1, -1, 0);

      // Reference skewed by one sample on a ramp: mismatch every sample until saturation.
      for (int i = 0; i < 22; i++) enc(1'b1, 1'b1, 6'((i % 19) - 9), 4'((i % 7) - 3), -1, 1, 1'b0);
      check("ecnt_sat", 32'(err_cnt), 32'(EMAX));

      // clk_en toggling: holds on idle cycles, latency counted in qualified edges.
      drive(1'b0, 1'b1, 1'b1, 6'd0, 4'd0, '0, '0, '0, '0);
      bk = 0; hist_b.delete(); hist_c.delete();
      model_reset();
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) rand_enc(1'b1, (i == 20) ? 0 : -1, 0);
         else enc(1'b0, 1'b1, 6'd0, 4'd0, -1, 0, 1'b0);
      end

      // Checking disabled: corrupted ST and skewed refs are ignored.
      for (int i = 0; i < 6; i++) rand_enc(1'b0, 5, 1);
      repeat (3) rand_enc(1'b1, -1, 0);

      repeat (3) enc(1'b0, 1'b1, 6'd0, 4'd0, -1, 0, 1'b0);
      check("drain", 32'(q_exp.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
